// File: rtl/simd_alu_pipe.sv
// -----------------------------------------------------------------------------
// simd_alu_pipe
//
// Two-stage pipelined add/sub/reduction unit with valid/ready handshakes on
// both sides. Sits between decode/register-read and execute writeback.
//
// Operations (op):
//   2'b00 ADD    : full-width signed add, saturating
//   2'b01 SUB    : full-width signed subtract (a - b), saturating
//   2'b10 PADDSB : lane-wise signed saturating add, LANE_W-bit lanes
//   2'b11 RED    : signed sum of all per-lane (a_lane + b_lane) pair sums,
//                  sign-extended to WIDTH, never saturates
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; op, a, b are the payload
//   out_valid/out_ready output handshake; result, ovfl are the payload
//   err_sticky        OR of ovfl over all output transfers since reset/clear
//   err_clr           clears err_sticky (a same-cycle setting transfer wins)
//   ovfl_cnt          (only with SIMD_ALU_OVFL_CNT_EN defined) saturating
//                     16-bit count of output transfers with ovfl=1
//
// Optional feature macro: SIMD_ALU_OVFL_CNT_EN
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready may depend combinationally on downstream ready.
// -----------------------------------------------------------------------------
module simd_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    input  logic             err_clr,
    output logic             err_sticky
`ifdef SIMD_ALU_OVFL_CNT_EN
    ,
    output logic [15:0]      ovfl_cnt
`endif
);

    localparam int NL = WIDTH / LANE_W;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PADDSB = 2'b10,
        OP_RED    = 2'b11
    } op_e;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_adv;
    logic in_xfer;
    logic out_xfer;

    assign s2_adv   = !out_valid || out_ready;   // S2 empty or draining
    assign in_ready = !s1_valid || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Stage 1: per-lane sums, each LANE_W+1 bits wide
    // ------------------------------------------------------------------
    op_e                     op_d;
    logic [WIDTH-1:0]        b_eff;
    logic                    carry;
    logic [LANE_W-1:0]       a_l;
    logic [LANE_W-1:0]       b_l;
    logic [NL-1:0][LANE_W:0] lane_sum_d;

    assign op_d = op_e'(op);

    always_comb begin
        b_eff      = (op_d == OP_SUB) ? ~b : b;
        carry      = (op_d == OP_SUB);
        a_l        = '0;
        b_l        = '0;
        lane_sum_d = '0;
        for (int i = 0; i < NL; i++) begin
            a_l = a[i*LANE_W +: LANE_W];
            b_l = b_eff[i*LANE_W +: LANE_W];
            if (op_d == OP_ADD || op_d == OP_SUB) begin
                // Carry ripples lane to lane: one full-width adder.
                lane_sum_d[i] = {1'b0, a_l} + {1'b0, b_l} + {{LANE_W{1'b0}}, carry};
                carry         = lane_sum_d[i][LANE_W];
            end else begin
                // Independent signed lane add; top bit is the sign extension.
                lane_sum_d[i] = {a_l[LANE_W-1], a_l} + {b_l[LANE_W-1], b_l};
            end
        end
    end

    op_e                     s1_op;
    logic [NL-1:0][LANE_W:0] s1_sum;
    logic                    s1_sa;   // sign of a
    logic                    s1_sb;   // sign of b after SUB inversion

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_sum   <= '0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_xfer) begin
                s1_op  <= op_d;
                s1_sum <= lane_sum_d;
                s1_sa  <= a[WIDTH-1];
                s1_sb  <= b_eff[WIDTH-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturation / reduction
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] full_sum;
    logic [WIDTH-1:0] padd_res;
    logic             padd_ovf;
    logic [WIDTH-1:0] red_acc;
    logic             add_ovf;
    logic [WIDTH-1:0] s2_result;
    logic             s2_ovfl;

    always_comb begin
        full_sum = '0;
        padd_res = '0;
        padd_ovf = 1'b0;
        red_acc  = '0;
        for (int i = 0; i < NL; i++) begin
            full_sum[i*LANE_W +: LANE_W] = s1_sum[i][LANE_W-1:0];
            // Lane overflow: sign-extension bit disagrees with lane MSB.
            if (s1_sum[i][LANE_W] != s1_sum[i][LANE_W-1]) begin
                padd_ovf = 1'b1;
                padd_res[i*LANE_W +: LANE_W] =
                    {s1_sum[i][LANE_W], {(LANE_W-1){~s1_sum[i][LANE_W]}}};
            end else begin
                padd_res[i*LANE_W +: LANE_W] = s1_sum[i][LANE_W-1:0];
            end
            red_acc = red_acc + WIDTH'($signed(s1_sum[i]));
        end

        add_ovf = (s1_sa == s1_sb) && (full_sum[WIDTH-1] != s1_sa);

        s2_result = full_sum;
        s2_ovfl   = 1'b0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                s2_ovfl   = add_ovf;
                s2_result = add_ovf ? (s1_sa ? SAT_NEG : SAT_POS) : full_sum;
            end
            OP_PADDSB: begin
                s2_ovfl   = padd_ovf;
                s2_result = padd_res;
            end
            OP_RED: begin
                s2_ovfl   = 1'b0;
                s2_result = red_acc;
            end
            default: begin
                s2_ovfl   = 1'b0;
                s2_result = full_sum;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= s2_result;
                ovfl   <= s2_ovfl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error tracking: a setting transfer takes priority over err_clr
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (out_xfer && ovfl) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef SIMD_ALU_OVFL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfl_cnt <= '0;
        end else if (out_xfer && ovfl) begin
            if (ovfl_cnt != 16'hFFFF) begin
                ovfl_cnt <= ovfl_cnt + 16'd1;
            end
        end else if (err_clr) begin
            ovfl_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_simd_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_alu_pipe
//
// Directed testbench for simd_alu_pipe (WIDTH=16, LANE_W=4). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_simd_alu_pipe;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         ovfl;
  logic         err_clr = 1'b0;
  logic         err_sticky;
`ifdef SIMD_ALU_OVFL_CNT_EN
  logic [15:0]  ovfl_cnt;
`endif

  simd_alu_pipe #(.WIDTH(W), .LANE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .ovfl       (ovfl),
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
`ifdef SIMD_ALU_OVFL_CNT_EN
    ,
    .ovfl_cnt   (ovfl_cnt)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, PADD = 2'b10, RED = 2'b11;

  // ---------------- driver ----------------
  // Issue one op into an empty pipeline and wait for its result.
  // lat = cycles from drive to out_valid, or -1 if it never appeared.
  task automatic issue_and_wait(input logic [1:0] o, input logic [W-1:0] av,
                                input logic [W-1:0] bv, output logic [W-1:0] r,
                                output logic ov, output int lat);
    @(negedge clk);
    op = o; a = av; b = bv; in_valid = 1'b1;
    lat = -1;
    r = 'x;
    ov = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        r = result;
        ov = ovfl;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 16'h0000) $display("FAIL rst_result got=%h exp=0000", result); else pass_cnt++;
    total_cnt++; if (ovfl !== 1'b0) $display("FAIL rst_ovfl got=%b exp=0", ovfl); else pass_cnt++;
    total_cnt++; if (err_sticky !== 1'b0) $display("FAIL rst_err_sticky got=%b exp=0", err_sticky); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
`ifdef SIMD_ALU_OVFL_CNT_EN
    total_cnt++; if (ovfl_cnt !== 16'h0000) $display("FAIL rst_ovfl_cnt got=%h exp=0000", ovfl_cnt); else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r;
    logic ov;
    int lat;
    out_ready = 1'b1;
    issue_and_wait(ADD, 16'h7FFF, 16'h0001, r, ov, lat);
    total_cnt++; if (lat !== 2) $display("FAIL add_sat_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++; if (r !== 16'h7FFF) $display("FAIL add_sat_result got=%h exp=7fff", r); else pass_cnt++;
    total_cnt++; if (ov !== 1'b1) $display("FAIL add_sat_ovfl got=%b exp=1", ov); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (err_sticky !== 1'b1) $display("FAIL add_sat_sticky got=%b exp=1", err_sticky); else pass_cnt++;
`ifdef SIMD_ALU_OVFL_CNT_EN
    total_cnt++; if (ovfl_cnt !== 16'h0001) $display("FAIL ovfl_cnt_one got=%h exp=0001", ovfl_cnt); else pass_cnt++;
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total_cnt++; if (err_sticky !== 1'b0) $display("FAIL clr_sticky got=%b exp=0", err_sticky); else pass_cnt++;

    issue_and_wait(ADD, 16'h1234, 16'h1111, r, ov, lat);
    total_cnt++; if (r !== 16'h2345 || ov !== 1'b0) $display("FAIL add_plain got=%h/%b exp=2345/0", r, ov); else pass_cnt++;
    issue_and_wait(SUB, 16'h8000, 16'h0001, r, ov, lat);
    total_cnt++; if (r !== 16'h8000 || ov !== 1'b1) $display("FAIL sub_sat got=%h/%b exp=8000/1", r, ov); else pass_cnt++;
    issue_and_wait(SUB, 16'h8000, 16'h8000, r, ov, lat);
    total_cnt++; if (r !== 16'h0000 || ov !== 1'b0) $display("FAIL sub_minmin got=%h/%b exp=0000/0", r, ov); else pass_cnt++;
    issue_and_wait(SUB, 16'h0005, 16'h0007, r, ov, lat);
    total_cnt++; if (r !== 16'hFFFE || ov !== 1'b0) $display("FAIL sub_neg got=%h/%b exp=fffe/0", r, ov); else pass_cnt++;
  endtask

  task automatic test_paddsb();
    logic [W-1:0] r;
    logic ov;
    int lat;
    issue_and_wait(PADD, 16'h8009, 16'h9009, r, ov, lat);
    total_cnt++; if (r !== 16'h8008 || ov !== 1'b1) $display("FAIL paddsb_neg got=%h/%b exp=8008/1", r, ov); else pass_cnt++;
    issue_and_wait(PADD, 16'h0FD8, 16'h0019, r, ov, lat);
    total_cnt++; if (r !== 16'h0FE8 || ov !== 1'b1) $display("FAIL paddsb_mix got=%h/%b exp=0fe8/1", r, ov); else pass_cnt++;
    // Lane-isolated: 7+1 saturates to 7 in lane 0 only, no carry into lane 1.
    issue_and_wait(PADD, 16'h1237, 16'h1111, r, ov, lat);
    total_cnt++; if (r !== 16'h2347 || ov !== 1'b1) $display("FAIL paddsb_pos got=%h/%b exp=2347/1", r, ov); else pass_cnt++;
    issue_and_wait(PADD, 16'h1234, 16'h1111, r, ov, lat);
    total_cnt++; if (r !== 16'h2345 || ov !== 1'b0) $display("FAIL paddsb_plain got=%h/%b exp=2345/0", r, ov); else pass_cnt++;
  endtask

  task automatic test_red();
    logic [W-1:0] r;
    logic ov;
    int lat;
    issue_and_wait(RED, 16'h1111, 16'h1111, r, ov, lat);
    total_cnt++; if (r !== 16'h0008 || ov !== 1'b0) $display("FAIL red_pos got=%h/%b exp=0008/0", r, ov); else pass_cnt++;
    issue_and_wait(RED, 16'hFFFF, 16'hFFFF, r, ov, lat);
    total_cnt++; if (r !== 16'hFFF8 || ov !== 1'b0) $display("FAIL red_neg got=%h/%b exp=fff8/0", r, ov); else pass_cnt++;
    // 7+7 per lane = 14, four lanes = 56 = 0x0038.
    issue_and_wait(RED, 16'h7777, 16'h7777, r, ov, lat);
    total_cnt++; if (r !== 16'h0038 || ov !== 1'b0) $display("FAIL red_max got=%h/%b exp=0038/0", r, ov); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals[4];
    logic exp_v;
    vals[0] = 16'h0010; vals[1] = 16'h0020; vals[2] = 16'h0030; vals[3] = 16'h0040;
    out_ready = 1'b1;
    exp_q.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 2 && cyc <= 5);
      total_cnt++; if (out_valid !== exp_v) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); else pass_cnt++;
      if (out_valid && exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        total_cnt++; if (result !== e) $display("FAIL b2b_result cyc=%0d got=%h exp=%h", cyc, result, e); else pass_cnt++;
      end
      if (cyc < 4) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); else pass_cnt++;
        op = ADD; a = vals[cyc]; b = 16'h0001; in_valid = 1'b1;
        exp_q.push_back(vals[cyc] + 16'h0001);
      end else begin
        in_valid = 1'b0;
      end
    end
    total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_stall();
    exp_q.delete();
    out_ready = 1'b0;
    @(negedge clk);                      // c0
    op = ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    exp_q.push_back(16'h0002);
    @(negedge clk);                      // c1: op1 in S1
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_ready_c1 got=%b exp=1", in_ready); else pass_cnt++;
    a = 16'h0002; b = 16'h0002;
    exp_q.push_back(16'h0004);
    @(negedge clk);                      // c2: op1 in S2, op2 in S1
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_ready_c2 got=%b exp=0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || result !== 16'h0002) $display("FAIL stall_hold_c2 got=%b/%h exp=1/0002", out_valid, result); else pass_cnt++;
    a = 16'h0003; b = 16'h0003;
    exp_q.push_back(16'h0006);
    @(negedge clk);                      // c3: still stalled
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_ready_c3 got=%b exp=0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || result !== 16'h0002) $display("FAIL stall_hold_c3 got=%b/%h exp=1/0002", out_valid, result); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] e;
      if (k == 1) in_valid = 1'b0;       // op3 was accepted on the first drain edge
      e = exp_q.pop_front();
      total_cnt++; if (out_valid !== 1'b1 || result !== e) $display("FAIL stall_drain k=%0d got=%b/%h exp=1/%h", k, out_valid, result, e); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_empty got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    @(negedge clk);
    op = ADD; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0100; b = 16'h0001;
    @(negedge clk);                      // both stages full
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL async_rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL async_rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rst_discard got=%0d exp=0", seen); else pass_cnt++;
    total_cnt++; if (err_sticky !== 1'b0) $display("FAIL rst_discard_sticky got=%b exp=0", err_sticky); else pass_cnt++;
  endtask

  task automatic test_clr_vs_set();
    out_ready = 1'b1;
    @(negedge clk);
    op = ADD; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || ovfl !== 1'b1) $display("FAIL clrset_out got=%b/%b exp=1/1", out_valid, ovfl); else pass_cnt++;
    err_clr = 1'b1;                      // same cycle as the ovfl transfer
    @(negedge clk);
    total_cnt++; if (err_sticky !== 1'b1) $display("FAIL clrset_sticky got=%b exp=1", err_sticky); else pass_cnt++;
    @(negedge clk);                      // clr alone now clears
    err_clr = 1'b0;
    total_cnt++; if (err_sticky !== 1'b0) $display("FAIL clr_after got=%b exp=0", err_sticky); else pass_cnt++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_sub();
    test_paddsb();
    test_red();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_clr_vs_set();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
